// File: rtl/ntt_result_unloader.sv
// Reads N coefficients out of the NTT core's registered read port and streams them
// on a valid/ready interface, optionally in bit-reversed address order.
module ntt_result_unloader #(
    parameter int N               = 256,
    parameter int WIDTH           = 32,
    parameter int ADDR_WIDTH      = 8,
    parameter bit BIT_REVERSE_OUT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  src_busy,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [WIDTH-1:0]      mem_read_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WIDTH-1:0]      m_data,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_last
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_STREAM = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] CNT_N    = (ADDR_WIDTH+1)'(N);
    localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'(N - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    function automatic logic [ADDR_WIDTH-1:0] bit_rev(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            r[i] = a[ADDR_WIDTH-1-i];
        end
        return r;
    endfunction

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   issue_cnt_q, issue_cnt_d;
    logic [ADDR_WIDTH:0]   beat_cnt_q, beat_cnt_d;
    logic                  done_q, done_d;
    logic                  inflight_q;
    logic [ADDR_WIDTH-1:0] infl_addr_q;
    logic                  infl_last_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [WIDTH-1:0]      fifo_data_q [2];
    logic [ADDR_WIDTH-1:0] fifo_addr_q [2];
    logic                  fifo_last_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            occ_q;

    logic                  pop_s, push_s, issue_s, final_pop_s, in_flow_s;
    logic [2:0]            occ_after_s;
    logic [ADDR_WIDTH-1:0] issue_addr_s;

    // Read-issue throttle: the read latency means an issue now lands one edge later,
    // so count the in-flight read against the two FIFO slots.
    always_comb begin
        pop_s        = (occ_q != 2'd0) & m_ready;
        push_s       = inflight_q;
        occ_after_s  = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop_s};
        issue_s      = (state_q == S_STREAM) && (issue_cnt_q < CNT_N) && (occ_after_s < 3'd2);
        issue_addr_s = BIT_REVERSE_OUT ? bit_rev(issue_cnt_q[ADDR_WIDTH-1:0])
                                       : issue_cnt_q[ADDR_WIDTH-1:0];
        final_pop_s  = pop_s && (beat_cnt_q == CNT_LAST);
        in_flow_s    = (state_q == S_STREAM) || (state_q == S_DRAIN);
    end

    // FSM next state, counters and done pulse
    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        if (issue_s) begin
            issue_cnt_d = issue_cnt_q + CNT_ONE;
        end else begin
            issue_cnt_d = issue_cnt_q;
        end
        if (pop_s) begin
            beat_cnt_d = beat_cnt_q + CNT_ONE;
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    issue_cnt_d = '0;
                    beat_cnt_d  = '0;
                    state_d     = src_busy ? S_WAIT : S_STREAM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!src_busy) begin
                    state_d = S_STREAM;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_STREAM: begin
                if (issue_s && (issue_cnt_q == CNT_LAST)) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_DRAIN: begin
                if (final_pop_s) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers and the in-flight read tag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            done_q      <= 1'b0;
            inflight_q  <= 1'b0;
            infl_addr_q <= '0;
            infl_last_q <= 1'b0;
            raddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            done_q      <= done_d;
            inflight_q  <= issue_s;
            if (issue_s) begin
                infl_addr_q <= issue_addr_s;
                infl_last_q <= (issue_cnt_q == CNT_LAST);
                raddr_q     <= issue_addr_s;
            end
        end
    end

    // Two-entry output FIFO fed by the returning read data
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_addr_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_data_q[wr_ptr_q] <= mem_read_data;
                fifo_addr_q[wr_ptr_q] <= infl_addr_q;
                fifo_last_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // The read address is presented in the issue cycle so the core's registered
    // read lands in time for full-rate streaming; otherwise it holds.
    assign mem_read_addr = issue_s ? issue_addr_s : raddr_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign m_valid       = (occ_q != 2'd0);
    assign m_data        = fifo_data_q[rd_ptr_q];
    assign m_addr        = fifo_addr_q[rd_ptr_q];
    assign m_last        = fifo_last_q[rd_ptr_q];

    ntt_result_unloader_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push_s),
        .pop_i     (pop_s),
        .occ_i     (occ_q),
        .in_flow_i (in_flow_s),
        .src_busy_i(src_busy)
    );

endmodule

// Protocol and FIFO-integrity checks for the unloader.
module ntt_result_unloader_chk (
    input logic       clk,
    input logic       rst,
    input logic       push_i,
    input logic       pop_i,
    input logic [1:0] occ_i,
    input logic       in_flow_i,
    input logic       src_busy_i
);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && !pop_i && (occ_i == 2'd2)));

    a_occ_range: assert property (@(posedge clk) disable iff (rst)
        (occ_i <= 2'd2));

    a_src_quiet: assert property (@(posedge clk) disable iff (rst)
        !(in_flow_i && src_busy_i));

endmodule

// File: tb/tb_ntt_result_unloader.sv
// Scoreboard bench: an in-order and a bit-reversed unloader run side by side on shared stimulus.
module tb_ntt_result_unloader;

    localparam int N  = 256;
    localparam int W  = 32;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst, start, src_busy, m_ready;
    logic busy0, done0, mv0, ml0, busy1, done1, mv1, ml1;
    logic [AW-1:0] mra0, ma0, mra1, ma1;
    logic [W-1:0]  rd0, md0, rd1, md1;

    logic [AW+W:0] q0[$];
    logic [AW+W:0] q1[$];
    int n_chk = 0, n_fail = 0;
    int beats0 = 0, beats1 = 0, dones0 = 0, dones1 = 0;
    bit rnd_mode = 1'b0, stall_done = 1'b0;
    int bp_base = 0;

    always #5 clk = ~clk;

    ntt_result_unloader #(.N(N), .WIDTH(W), .ADDR_WIDTH(AW), .BIT_REVERSE_OUT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .src_busy(src_busy), .busy(busy0), .done(done0),
        .mem_read_addr(mra0), .mem_read_data(rd0), .m_valid(mv0), .m_ready(m_ready),
        .m_data(md0), .m_addr(ma0), .m_last(ml0));

    ntt_result_unloader #(.N(N), .WIDTH(W), .ADDR_WIDTH(AW), .BIT_REVERSE_OUT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .src_busy(src_busy), .busy(busy1), .done(done1),
        .mem_read_addr(mra1), .mem_read_data(rd1), .m_valid(mv1), .m_ready(m_ready),
        .m_data(md1), .m_addr(ma1), .m_last(ml1));

    // Core memory model: mem[i] = i*3+1 behind a registered read port
    always_ff @(posedge clk) begin
        rd0 <= {24'd0, mra0} * 32'd3 + 32'd1;
        rd1 <= {24'd0, mra1} * 32'd3 + 32'd1;
    end

    function automatic logic [AW-1:0] rev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
        return r;
    endfunction

    function automatic logic [AW+W:0] exp_beat(input int k, input bit br);
        logic [AW-1:0] kk, a;
        kk = k[AW-1:0];
        a  = br ? rev(kk) : kk;
        return {(k == N - 1), a, {24'd0, a} * 32'd3 + 32'd1};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake and checks beats hold under stall
    initial begin
        logic [AW+W:0] prev0, prev1, e;
        bit pst0, pst1;
        pst0 = 1'b0; pst1 = 1'b0; prev0 = '0; prev1 = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q0.delete(); q1.delete();
                pst0 = 1'b0; pst1 = 1'b0;
            end else begin
                if (pst0) begin
                    chk("hold0_valid", mv0, 1);
                    chk("hold0_beat", {ml0, ma0, md0}, prev0);
                end
                if (pst1) begin
                    chk("hold1_valid", mv1, 1);
                    chk("hold1_beat", {ml1, ma1, md1}, prev1);
                end
                if (mv0 && m_ready) begin
                    beats0++;
                    chk("sb0_has_entry", (q0.size() != 0), 1);
                    if (q0.size() != 0) begin
                        e = q0.pop_front();
                        chk("beat0", {ml0, ma0, md0}, e);
                    end
                end
                if (mv1 && m_ready) begin
                    beats1++;
                    chk("sb1_has_entry", (q1.size() != 0), 1);
                    if (q1.size() != 0) begin
                        e = q1.pop_front();
                        chk("beat1", {ml1, ma1, md1}, e);
                    end
                end
                pst0 = mv0 && !m_ready; prev0 = {ml0, ma0, md0};
                pst1 = mv1 && !m_ready; prev1 = {ml1, ma1, md1};
                if (done0) dones0++;
                if (done1) dones1++;
            end
        end
    end

    // Sink ready: always high, or ~30% random with one 20-cycle stall at beat 100
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rnd_mode && !stall_done && (beats0 - bp_base) >= 100) begin
                stall_done = 1'b1;
                m_ready = 1'b0;
                repeat (20) @(posedge clk);
                #1;
            end
            if (rnd_mode) m_ready = ($urandom_range(0, 99) < 30);
            else          m_ready = 1'b1;
        end
    end

    task automatic do_start(input bit expect_accept);
        if (expect_accept) begin
            for (int k = 0; k < N; k++) begin
                q0.push_back(exp_beat(k, 1'b0));
                q1.push_back(exp_beat(k, 1'b1));
            end
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); cyc++;
            @(negedge clk);
        end while (!done0 && cyc < limit);
        chk("done_seen", done0, 1);
    endtask

    task automatic end_scn(input string tag, input int b0, input int b1, input int d0, input int d1);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_beats0"}, beats0 - b0, N);
        chk({tag, "_beats1"}, beats1 - b1, N);
        chk({tag, "_dones0"}, dones0 - d0, 1);
        chk({tag, "_dones1"}, dones1 - d1, 1);
        chk({tag, "_sb_empty"}, q0.size() + q1.size(), 0);
        chk({tag, "_idle"}, {busy0, busy1, mv0, mv1}, 0);
    endtask

    // Full-rate unload with exact latency checks
    task automatic run_full(input string tag);
        int b0, b1, d0, d1, cyc;
        b0 = beats0; b1 = beats1; d0 = dones0; d1 = dones1;
        do_start(1'b1);
        @(negedge clk);
        chk({tag, "_busy_e0"}, {busy0, busy1}, 2'b11);
        chk({tag, "_valid_e0"}, {mv0, mv1}, 0);
        @(posedge clk); @(negedge clk);
        chk({tag, "_valid_e1"}, {mv0, mv1}, 0);
        @(posedge clk); @(negedge clk);
        chk({tag, "_valid_e2"}, {mv0, mv1}, 2'b11);
        chk({tag, "_first0"}, {ml0, ma0, md0}, exp_beat(0, 1'b0));
        chk({tag, "_first1"}, {ml1, ma1, md1}, exp_beat(0, 1'b1));
        wait_done(N + 20, cyc);
        chk({tag, "_done_lat"}, cyc, N);
        chk({tag, "_done1_sync"}, done1, 1);
        chk({tag, "_busy_at_done"}, {busy0, busy1}, 0);
        @(posedge clk); @(negedge clk);
        chk({tag, "_done_pulse"}, {done0, done1}, 0);
        end_scn(tag, b0, b1, d0, d1);
    endtask

    initial begin
        int b0, b1, d0, d1, cyc;
        logic [AW-1:0] hold0, hold1;
        bit any_valid;
        rst = 1'b1; start = 1'b0; src_busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset0", {busy0, done0, mv0, ml0, ma0, md0, mra0}, 0);
        chk("reset1", {busy1, done1, mv1, ml1, ma1, md1, mra1}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // In-order and bit-reversed, full rate
        run_full("full");

        // Backpressure plus a redundant start mid-stream
        b0 = beats0; b1 = beats1; d0 = dones0; d1 = dones1;
        bp_base = beats0;
        rnd_mode = 1'b1;
        do_start(1'b1);
        repeat (30) @(posedge clk);
        #1;
        do_start(1'b0);
        wait_done(5000, cyc);
        rnd_mode = 1'b0;
        end_scn("bp", b0, b1, d0, d1);
        chk("bp_stall_hit", stall_done, 1);

        // Deferred start while the core is busy
        b0 = beats0; b1 = beats1; d0 = dones0; d1 = dones1;
        src_busy = 1'b1;
        do_start(1'b1);
        @(negedge clk);
        chk("wait_busy", {busy0, busy1}, 2'b11);
        hold0 = mra0; hold1 = mra1;
        any_valid = 1'b0;
        repeat (14) begin
            @(posedge clk); @(negedge clk);
            any_valid = any_valid | mv0 | mv1;
        end
        chk("wait_no_valid", any_valid, 0);
        chk("wait_addr_hold", {mra0, mra1}, {hold0, hold1});
        @(posedge clk); #1;
        src_busy = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("wait_valid_f1", {mv0, mv1}, 0);
        @(posedge clk); @(negedge clk);
        chk("wait_valid_f2", {mv0, mv1}, 0);
        @(posedge clk); @(negedge clk);
        chk("wait_valid_f3", {mv0, mv1}, 2'b11);
        wait_done(N + 20, cyc);
        chk("wait_done_lat", cyc, N);
        end_scn("wait", b0, b1, d0, d1);

        // Reset at beat 57 aborts the unload
        d0 = dones0; d1 = dones1; b0 = beats0;
        do_start(1'b1);
        cyc = 0;
        while ((beats0 - b0) < 57 && cyc < 1000) begin
            @(posedge clk); #2;
            cyc++;
        end
        chk("abort_reached_57", (beats0 - b0) >= 57, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_out0", {busy0, done0, mv0, ml0, ma0, md0, mra0}, 0);
        chk("abort_out1", {busy1, done1, mv1, ml1, ma1, md1, mra1}, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_done", (dones0 - d0) + (dones1 - d1), 0);
        chk("abort_quiet", {busy0, busy1, mv0, mv1}, 0);

        // Fresh unload after the abort starts from beat 0
        run_full("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
